pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Instruction-fetch front end: owns the architectural PC register, steps it by PC_STEP,
//  issues one instruction-memory read at a time, and presents {pc, instr} to decode.
//  Consumes the next-PC increment (internal +PC_STEP) and decode/execute redirects.
//  Sits between imem and the IF/ID stage; one request outstanding max.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  PC_STEP   32'd4          sequential PC increment
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   asynchronous reset, active-low
//  redirect_valid  in   1   branch/jump taken: load redirect_pc, flush fetch
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (forced 2'b00)
//  imem_req_valid  out  1   read request valid
//  imem_req_addr   out  32  read address (PC of request)
//  imem_req_ready  in   1   imem accepts request when valid&&ready
//  imem_rsp_valid  in   1   one-cycle pulse: read data valid, >=1 cycle after accept
//  imem_rsp_data   in   32  instruction word
//  if_valid        out  1   output buffer holds a valid instruction
//  if_pc           out  32  PC of buffered instruction
//  if_instr        out  32  buffered instruction
//  if_ready        in   1   decode consumes buffer when if_valid&&if_ready
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0,
//   imem_req_valid=0, imem_req_addr=RESET_PC. First clock after release: IDLE->REQ.
//  States: IDLE, REQ, WAIT, DRAIN. Registered: pc, req_pc, if_* buffer, state.
//  space = !if_valid || if_ready (buffer empty or draining this cycle).
//  imem_req_valid = (state==REQ) && space (combinational); imem_req_addr = pc.
//   Request may be retracted (space drops, or redirect); imem samples only on valid&&ready.
//  REQ:  on valid&&ready -> req_pc<=pc, pc<=pc+PC_STEP (mod 2^32), -> WAIT.
//  WAIT: on imem_rsp_valid -> if_pc<=req_pc, if_instr<=rsp_data, if_valid<=1, -> REQ.
//   Space is guaranteed: request issued only when space=1, nothing else fills buffer.
//  Buffer: if_valid&&if_ready with no new load -> if_valid<=0. Load and consume same
//   cycle -> buffer replaced, if_valid stays 1. Outputs held stable while if_ready=0.
//  Best throughput: 1 instr per 2 cycles (REQ accept, rsp next cycle).
//  Redirect (highest priority, any state except IDLE): pc<={redirect_pc[31:2],2'b00},
//   if_valid<=0 (buffer flushed, even if being consumed this cycle), then:
//   - in REQ, request not accepted this cycle -> stay REQ (new pc next cycle).
//   - in REQ, request accepted same cycle     -> DRAIN (in-flight read must be dropped).
//   - in WAIT, no rsp this cycle              -> DRAIN.
//   - in WAIT, rsp same cycle                 -> rsp discarded, -> REQ.
//   - in DRAIN, rsp same cycle                -> stays target pc, -> REQ.
//   - in DRAIN, no rsp this cycle             -> stay DRAIN.
//   No pc+PC_STEP on a redirect cycle; redirect_pc wins.
//  DRAIN: imem_req_valid=0; on imem_rsp_valid discard data -> REQ.
//  Wrap: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
//  Reset mid-operation: everything returns to reset values immediately; a stale
//   imem_rsp_valid arriving in IDLE/REQ is ignored (rsp only consumed in WAIT/DRAIN).
// TESTING
//  1 Reset, imem ready=1, rsp 1 cycle later, if_ready=1 -> if_pc 0,4,8,C, 1 instr/2 cycles.
//  2 Hold if_ready=0 with if_valid=1 -> imem_req_valid=0, if_pc/instr stable; release -> resume at next pc.
//  3 redirect_pc=0x100 while in WAIT -> if_valid=0, late rsp dropped, next req addr 0x100, if_pc=0x100.
//  4 Redirect 0x203 same cycle as rsp in WAIT -> rsp dropped, next req addr 0x200, no DRAIN cycle.
//  5 RESET_PC=32'hFFFF_FFFC -> first if_pc FFFF_FFFC, next req addr 0x0000_0000.
//  6 rst_n low while in WAIT, rsp pulse during reset/IDLE -> if_valid=0, first req addr RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bundle: imem request/response, decode-side output buffer and redirect input.
// The master side is the fetch controller. The slave side is the imem/decode environment.
interface pc_fetch_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch front end: owns the PC and keeps one imem read in flight at most.
// It buffers {pc, instr} for decode and handles redirects by flushing and dropping stale reads.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic            clk,
  input logic            rst_n,
  pc_fetch_ctrl_if.master f
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc, req_pc;
  logic        if_valid_q;
  logic [31:0] if_pc_q, if_instr_q;
  logic        space, req_fire, redir;
  logic [31:0] redir_pc;

  // A request is offered only when the buffer can take its response. Because of that,
  // a response arriving in WAIT never finds the buffer occupied.
  assign space            = !if_valid_q || f.if_ready;
  assign f.imem_req_valid = (state == S_REQ) && space;
  assign f.imem_req_addr  = pc;
  assign req_fire         = f.imem_req_valid && f.imem_req_ready;
  assign redir            = f.redirect_valid && (state != S_IDLE);
  assign redir_pc         = {f.redirect_pc[31:2], 2'b00};

  assign f.if_valid = if_valid_q;
  assign f.if_pc    = if_pc_q;
  assign f.if_instr = if_instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
    end else if (redir) begin
      // A redirect overrides both the increment and any response.
      // An accepted or outstanding read must still drain before the next request.
      pc         <= redir_pc;
      if_valid_q <= 1'b0;
      unique case (state)
        S_REQ:   state <= req_fire ? S_DRAIN : S_REQ;
        S_WAIT:  state <= f.imem_rsp_valid ? S_REQ : S_DRAIN;
        S_DRAIN: state <= f.imem_rsp_valid ? S_REQ : S_DRAIN;
        default: state <= S_REQ;
      endcase
    end else begin
      if (if_valid_q && f.if_ready) if_valid_q <= 1'b0;
      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: if (req_fire) begin
          req_pc <= pc;
          pc     <= pc + PC_STEP;
          state  <= S_WAIT;
        end
        S_WAIT: if (f.imem_rsp_valid) begin
          if_valid_q <= 1'b1;
          if_pc_q    <= req_pc;
          if_instr_q <= f.imem_rsp_data;
          state      <= S_REQ;
        end
        S_DRAIN: if (f.imem_rsp_valid) state <= S_REQ;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a main DUT served by an imem responder with programmable latency.
// A second instance with RESET_PC=FFFF_FFFC is driven by hand for wrap and accepted-redirect cases.
module tb_pc_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if fa ();
  pc_fetch_ctrl_if fb ();

  pc_fetch_ctrl dut_a (.clk(clk), .rst_n(rst_n), .f(fa.master));
  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_b (.clk(clk), .rst_n(rst_n), .f(fb.master));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The imem model answers with data {C0DE, addr[15:0]} a programmable number of cycles after accept.
  int          lat = 1;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;
  initial begin
    fa.imem_rsp_valid = 1'b0;
    fa.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      fa.imem_rsp_valid = 1'b0;
      if (busy) begin
        if (cnt == 1) begin
          fa.imem_rsp_valid = 1'b1;
          fa.imem_rsp_data  = {16'hC0DE, paddr[15:0]};
          busy = 1'b0;
        end else cnt--;
      end
      if (fa.imem_req_valid && fa.imem_req_ready) begin
        busy = 1'b1; cnt = lat; paddr = fa.imem_req_addr;
      end
    end
  end

  task automatic cyc;
    @(posedge clk); #2;
  endtask

  initial begin
    fa.redirect_valid = 1'b0; fa.redirect_pc = 32'h0;
    fa.imem_req_ready = 1'b1; fa.if_ready = 1'b1;
    fb.redirect_valid = 1'b0; fb.redirect_pc = 32'h0;
    fb.imem_req_ready = 1'b0; fb.imem_rsp_valid = 1'b0; fb.imem_rsp_data = 32'h0;
    fb.if_ready = 1'b1;

    // reset values
    cyc; cyc;
    chk("rst_if_valid",  {31'h0, fa.if_valid}, 32'h0);
    chk("rst_if_pc",     fa.if_pc, 32'h0);
    chk("rst_if_instr",  fa.if_instr, 32'h0);
    chk("rst_req_valid", {31'h0, fa.imem_req_valid}, 32'h0);
    chk("rst_req_addr",  fa.imem_req_addr, 32'h0);
    chk("rst_b_req_addr", fb.imem_req_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // 1: sequential fetch, one instruction every two cycles
    cyc; // E1 IDLE->REQ
    chk("t1_req_valid", {31'h0, fa.imem_req_valid}, 32'h1);
    chk("t1_req_addr",  fa.imem_req_addr, 32'h0);
    cyc; cyc; // E3
    chk("t1_v0",     {31'h0, fa.if_valid}, 32'h1);
    chk("t1_pc0",    fa.if_pc, 32'h0);
    chk("t1_instr0", fa.if_instr, 32'hC0DE_0000);
    chk("t1_addr4",  fa.imem_req_addr, 32'h4);
    cyc; // E4
    chk("t1_gap", {31'h0, fa.if_valid}, 32'h0);
    cyc; // E5
    chk("t1_pc4", fa.if_pc, 32'h4);
    cyc; cyc; // E7
    chk("t1_pc8", fa.if_pc, 32'h8);
    cyc; cyc; // E9
    chk("t1_pcC", fa.if_pc, 32'hC);
    chk("t1_instrC", fa.if_instr, 32'hC0DE_000C);

    // 2: decode stall holds the buffer and withdraws the request
    fa.if_ready = 1'b0; #1;
    chk("t2_req_drop", {31'h0, fa.imem_req_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc; // E10..E12
      chk("t2_hold_v",     {31'h0, fa.if_valid}, 32'h1);
      chk("t2_hold_pc",    fa.if_pc, 32'hC);
      chk("t2_hold_instr", fa.if_instr, 32'hC0DE_000C);
      chk("t2_hold_req",   {31'h0, fa.imem_req_valid}, 32'h0);
    end
    fa.if_ready = 1'b1; #1;
    chk("t2_resume_addr", fa.imem_req_addr, 32'h10);
    chk("t2_resume_req",  {31'h0, fa.imem_req_valid}, 32'h1);
    cyc; cyc; // E14
    chk("t2_pc10", fa.if_pc, 32'h10);

    // 3: redirect while waiting on a slow read, late response dropped
    lat = 3;
    cyc; // E15 accept 0x14
    fa.redirect_valid = 1'b1; fa.redirect_pc = 32'h100;
    cyc; // E16 WAIT -> DRAIN
    fa.redirect_valid = 1'b0;
    chk("t3_flush",     {31'h0, fa.if_valid}, 32'h0);
    chk("t3_drain_req", {31'h0, fa.imem_req_valid}, 32'h0);
    cyc; // E17
    chk("t3_drain_req2", {31'h0, fa.imem_req_valid}, 32'h0);
    cyc; // E18 stale rsp discarded
    lat = 1;
    chk("t3_no_load",  {31'h0, fa.if_valid}, 32'h0);
    chk("t3_req_addr", fa.imem_req_addr, 32'h100);
    cyc; cyc; // E20
    chk("t3_if_pc",    fa.if_pc, 32'h100);
    chk("t3_if_instr", fa.if_instr, 32'hC0DE_0100);

    // 4: redirect to an unaligned target together with the response, no drain cycle
    cyc; // E21 accept 0x104
    fa.redirect_valid = 1'b1; fa.redirect_pc = 32'h203;
    cyc; // E22
    fa.redirect_valid = 1'b0;
    chk("t4_flush",     {31'h0, fa.if_valid}, 32'h0);
    chk("t4_req_valid", {31'h0, fa.imem_req_valid}, 32'h1);
    chk("t4_req_addr",  fa.imem_req_addr, 32'h200);
    cyc; cyc; // E24
    chk("t4_if_pc",    fa.if_pc, 32'h200);
    chk("t4_if_instr", fa.if_instr, 32'hC0DE_0200);

    // 6: reset while in WAIT, response pulse lands in IDLE
    lat = 2;
    cyc; // E25 accept 0x204
    rst_n = 1'b0; #1;
    chk("t6_rst_v",    {31'h0, fa.if_valid}, 32'h0);
    chk("t6_rst_req",  {31'h0, fa.imem_req_valid}, 32'h0);
    chk("t6_rst_addr", fa.imem_req_addr, 32'h0);
    cyc; // E26
    rst_n = 1'b1; lat = 1;
    cyc; // E27 stale rsp in IDLE
    chk("t6_v",        {31'h0, fa.if_valid}, 32'h0);
    chk("t6_req_addr", fa.imem_req_addr, 32'h0);
    cyc; cyc; // E29
    chk("t6_if_pc",    fa.if_pc, 32'h0);
    chk("t6_if_instr", fa.if_instr, 32'hC0DE_0000);

    // 5: PC wrap from FFFF_FFFC
    fb.imem_req_ready = 1'b1; #1;
    chk("t5_req_valid", {31'h0, fb.imem_req_valid}, 32'h1);
    chk("t5_req_addr",  fb.imem_req_addr, 32'hFFFF_FFFC);
    cyc; // E30 accept
    fb.imem_rsp_valid = 1'b1; fb.imem_rsp_data = 32'h1234_5678;
    cyc; // E31 load
    fb.imem_rsp_valid = 1'b0;
    chk("t5_if_pc",    fb.if_pc, 32'hFFFF_FFFC);
    chk("t5_if_instr", fb.if_instr, 32'h1234_5678);
    chk("t5_wrap",     fb.imem_req_addr, 32'h0);

    // 7: redirect in the same cycle a request is accepted forces a drain
    fb.redirect_valid = 1'b1; fb.redirect_pc = 32'h40;
    cyc; // E32 REQ accepted + redirect -> DRAIN
    fb.redirect_valid = 1'b0;
    chk("t7_flush",     {31'h0, fb.if_valid}, 32'h0);
    chk("t7_drain_req", {31'h0, fb.imem_req_valid}, 32'h0);
    fb.imem_rsp_valid = 1'b1; fb.imem_rsp_data = 32'hDEAD_BEEF;
    cyc; // E33 dropped rsp -> REQ
    fb.imem_rsp_valid = 1'b0;
    chk("t7_no_load",  {31'h0, fb.if_valid}, 32'h0);
    chk("t7_req_addr", fb.imem_req_addr, 32'h40);
    chk("t7_req_valid", {31'h0, fb.imem_req_valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
